// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit owning HI/LO.
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        launch MULT(00)/MULTU(01)/DIV(10)/DIVU(11), sampled when idle
//   rs_data, rt_data operands (multiplicand/dividend, multiplier/divisor)
//   mthi, mtlo       move rs_data into HI / LO while idle
//   busy, done       operation in progress / one-cycle result-written pulse
//   hi, lo           HI (product high / remainder), LO (product low / quotient)
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;       // {hi-half, lo-half} working register
    logic [WIDTH-1:0]   opb_q, opb_d;       // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d; // raw dividend for divide-by-zero result
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Operand sign/magnitude at launch; unsigned ops never flag a sign.
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    assign rs_neg = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg = ~op[0] & rt_data[WIDTH-1];
    assign rs_abs = rs_neg ? WIDTH'(-rs_data) : rs_data;
    assign rt_abs = rt_neg ? WIDTH'(-rt_data) : rt_data;

    // Shift-add step: add multiplicand to upper half when LSB set, shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[ACC_W-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};

    // Restoring divide step on {remainder, next dividend bit}.
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;
    assign div_shift = acc_q[ACC_W-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift - {1'b0, opb_q};

    // Sign-corrected results.
    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, rs_restored;
    assign prod_fix    = (neg_a_q ^ neg_b_q) ? ACC_W'(-acc_q) : acc_q;
    assign quo_fix     = (neg_a_q ^ neg_b_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix     = neg_a_q ? WIDTH'(-acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
    assign rs_restored = rs_raw_q;

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        rs_raw_d   = rs_raw_q;
        is_div_d   = is_div_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = rs_data;
                if (mtlo) lo_d = rs_data;
                if (start) begin
                    is_div_d   = op[1];
                    neg_a_d    = rs_neg;
                    neg_b_d    = rt_neg;
                    div_zero_d = (rt_data == {WIDTH{1'b0}});
                    rs_raw_d   = rs_data;
                    opb_d      = op[1] ? rt_abs : rs_abs;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                    cnt_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[ACC_W-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = rs_restored;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            rs_raw_q   <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            rs_raw_q   <= rs_raw_d;
            is_div_q   <= is_div_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
